// File: rtl/gen_seq_ctrl.sv
// gen_seq_ctrl: burst sequencer for a pattern generator; each frame is a one-cycle reload,
// a static select phase and a dynamic select phase, optionally followed by idle gap cycles.
module gen_seq_ctrl #(
    parameter int SIZESRSTAT = 88,
    parameter int SIZESRDYN  = 16,
    parameter int CNTW       = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [7:0]            nframes,
    input  logic [3:0]            gap,
    input  logic [SIZESRSTAT-1:0] stat_word,
    input  logic [SIZESRDYN-1:0]  dyn_word,
    output logic                  selstat,
    output logic                  seldyn,
    output logic [SIZESRSTAT-1:0] statreg,
    output logic [SIZESRDYN-1:0]  dynreg,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            frame_cnt
);
    typedef enum logic [2:0] {IDLE, LOAD, STAT, DYN, GAP} state_t;
    localparam logic [CNTW-1:0] STAT_LAST = CNTW'(SIZESRSTAT - 1);
    localparam logic [CNTW-1:0] DYN_LAST  = CNTW'(SIZESRDYN - 1);
    state_t          state, state_n;
    logic [CNTW-1:0] cnt, cnt_n;
    logic [7:0]      nframes_l, fc_inc;
    logic [3:0]      gap_l;
    logic            done_n, dyn_end;
    assign dyn_end = state == DYN && cnt == DYN_LAST;
    assign fc_inc  = frame_cnt == 8'hFF ? frame_cnt : frame_cnt + 8'd1;
    always_comb begin
        state_n = state;
        done_n  = 1'b0;
        if (state != IDLE && abort) begin
            state_n = IDLE;
            done_n  = 1'b1;
        end else begin
            case (state)
                IDLE: state_n = start ? LOAD : IDLE;
                LOAD: state_n = STAT;
                STAT: state_n = cnt == STAT_LAST ? DYN : STAT;
                DYN: begin
                    if (dyn_end) begin
                        // burst ends when the completed-frame count reaches a nonzero target
                        if (nframes_l != 8'd0 && nframes_l == fc_inc) begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end else begin
                            state_n = gap_l == 4'd0 ? LOAD : GAP;
                        end
                    end
                end
                GAP:     state_n = cnt == CNTW'(gap_l - 4'd1) ? LOAD : GAP;
                default: state_n = IDLE;
            endcase
        end
        cnt_n = (state_n == state && state != IDLE) ? cnt + 1'b1 : '0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            selstat   <= 1'b0;
            seldyn    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            statreg   <= '0;
            dynreg    <= '0;
            frame_cnt <= '0;
            nframes_l <= '0;
            gap_l     <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            selstat <= state_n == STAT;
            seldyn  <= state_n == DYN;
            busy    <= state_n != IDLE;
            done    <= done_n;
            if (state == IDLE && start) begin
                statreg   <= stat_word;
                dynreg    <= dyn_word;
                nframes_l <= nframes;
                gap_l     <= gap;
                frame_cnt <= '0;
            end
            if (state != IDLE && state_n == LOAD) dynreg <= dyn_word;
            if (dyn_end && !abort) frame_cnt <= fc_inc;
        end
    end
    assert property (@(posedge clk) disable iff (!rst_n)
        !(selstat && seldyn) && busy == (state != IDLE));
endmodule
